mul_div_unit: RTL and testbench

//  Multi-cycle multiply/divide unit (MDU) that sits beside the integer ALU in the EX stage.
//  It executes mult/multu/div/divu and writes the 64-bit result into the HI/LO registers.
//  It also services mthi/mtlo writes and mfhi/mflo reads.
//  The busy output, together with start, drives the pipeline stall logic for any MDU

---
 rtl/mul_div_unit.sv | 146 ++++++++++++++
 tb/tb_mul_div_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit for the EX stage.
// Operands are latched at issue, and the result is written to HI/LO at the last busy edge.
// mthi/mtlo write in one cycle when the unit is idle.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDU_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_hi,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] rd_data
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             issue;
    logic             fin;

    logic [2:0]  op_q;
    logic [31:0] a_q, b_q, b_div;
    logic signed [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] res;
    logic        res_wr;

    // Signed divide returning {remainder, quotient}; the most-negative by -1 case
    // wraps the quotient to 0x80000000 with a zero remainder instead of trapping.
    function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'sh8000_0000;
            r = 32'sd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    // State and cycle counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: accept mult/div only when idle, and finish when the counter reaches zero
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        issue     = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (start && (MDU_op == OP_MULT || MDU_op == OP_MULTU ||
                              MDU_op == OP_DIV  || MDU_op == OP_DIVU)) begin
                    issue     = 1'b1;
                    cnt_nxt   = (MDU_op == OP_MULT || MDU_op == OP_MULTU) ? MULT_LAST : DIV_LAST;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    fin       = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture at issue; later changes on A/B do not affect the result
    always_ff @(posedge clk) begin
        if (issue) begin
            op_q <= MDU_op;
            a_q  <= A;
            b_q  <= B;
        end
    end

    // The divisor is forced to 1 when it is zero so the arithmetic stays defined.
    // The write is suppressed in that case anyway.
    assign b_div  = (b_q == 32'd0) ? 32'd1 : b_q;
    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Result select from the latched operation
    always_comb begin
        res    = '0;
        res_wr = 1'b0;
        case (op_q)
            OP_MULT:  begin res = prod_s; res_wr = 1'b1; end
            OP_MULTU: begin res = prod_u; res_wr = 1'b1; end
            OP_DIV:   begin res = sdiv(a_q, b_div); res_wr = (b_q != 32'd0); end
            OP_DIVU:  begin res = {a_q % b_div, a_q / b_div}; res_wr = (b_q != 32'd0); end
            default:  begin res = '0; res_wr = 1'b0; end
        endcase
    end

    // HI/LO update: operation result at the final edge, otherwise mthi/mtlo while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            HI <= '0;
            LO <= '0;
        end else if (fin) begin
            if (res_wr) begin
                HI <= res[63:32];
                LO <= res[31:0];
            end
        end else if (state == IDLE && start) begin
            if (MDU_op == OP_MTHI) HI <= A;
            if (MDU_op == OP_MTLO) LO <= A;
        end
    end

    assign busy    = (state == RUN);
    assign rd_data = rd_hi ? HI : LO;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
// Inputs are driven and outputs sampled on the falling edge.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  MDU_op;
    logic [31:0] A, B;
    logic        rd_hi;
    logic        busy;
    logic [31:0] HI, LO, rd_data;

    int errors = 0;
    int checks = 0;

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .MDU_op(MDU_op),
        .A(A), .B(B), .rd_hi(rd_hi), .busy(busy),
        .HI(HI), .LO(LO), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a one-cycle start strobe; returns on the falling edge after the sampling edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        MDU_op = op;
        A      = a;
        B      = b;
        @(negedge clk);
        start  = 1'b0;
        MDU_op = 3'd0;
    endtask

    // Count falling edges with busy high, bounded
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n;

    initial begin
        reset = 1'b1; start = 1'b0; MDU_op = 3'd0; A = '0; B = '0; rd_hi = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        chk("reset_rd", rd_data, 32'd0);

        // mult -2 * 3
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_busy", {31'd0, busy}, 32'd1);
        chk("mult_hold_hi", HI, 32'd0);
        wait_idle(n);
        chk("mult_cycles", n, 32'd5);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFA);

        // multu max * max
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("multu_cycles", n, 32'd5);
        chk("multu_hi", HI, 32'hFFFF_FFFE);
        chk("multu_lo", LO, 32'h0000_0001);

        // div -7 / 2
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        chk("div_hold_lo", LO, 32'h0000_0001);
        wait_idle(n);
        chk("div_cycles", n, 32'd10);
        chk("div_lo", LO, 32'hFFFF_FFFD);
        chk("div_hi", HI, 32'hFFFF_FFFF);

        // divu of the same operands
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        chk("divu_lo", LO, 32'h7FFF_FFFC);
        chk("divu_hi", HI, 32'h0000_0001);

        // signed overflow case
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("divov_lo", LO, 32'h8000_0000);
        chk("divov_hi", HI, 32'h0000_0000);

        // mtlo / mthi take effect in one cycle without busy
        issue(3'd6, 32'h0000_1234, 32'd0);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mtlo_lo", LO, 32'h0000_1234);
        issue(3'd5, 32'h0000_ABCD, 32'd0);
        chk("mthi_hi", HI, 32'h0000_ABCD);

        // reserved opcode has no effect
        issue(3'd7, 32'hDEAD_BEEF, 32'd0);
        chk("op7_busy", {31'd0, busy}, 32'd0);
        chk("op7_hi", HI, 32'h0000_ABCD);

        // divu by zero with an mthi attempted during RUN
        issue(3'd4, 32'h0000_0077, 32'd0);
        issue(3'd5, 32'h5555_5555, 32'd0);
        chk("dz_mthi_ignored", HI, 32'h0000_ABCD);
        wait_idle(n);
        chk("dz_cycles", n + 1, 32'd10);
        chk("dz_lo", LO, 32'h0000_1234);
        chk("dz_hi", HI, 32'h0000_ABCD);

        // reset during mult busy cycle 3
        issue(3'd1, 32'd5, 32'd7);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        repeat (10) @(negedge clk);
        chk("rst_late_lo", LO, 32'd0);
        chk("rst_late_busy", {31'd0, busy}, 32'd0);

        // back-to-back: div 100/7, then mult on the first idle cycle
        issue(3'd3, 32'd100, 32'd7);
        wait_idle(n);
        chk("b2b_div_lo", LO, 32'd14);
        chk("b2b_div_hi", HI, 32'd2);
        issue(3'd1, 32'hFFFF_FFFD, 32'h0000_0010);
        chk("b2b_accept", {31'd0, busy}, 32'd1);
        A = 32'h1111_1111;
        B = 32'h2222_2222;
        wait_idle(n);
        chk("b2b_cycles", n, 32'd5);
        chk("b2b_hi", HI, 32'hFFFF_FFFF);
        chk("b2b_lo", LO, 32'hFFFF_FFD0);

        // rd_hi selects within the same cycle
        rd_hi = 1'b1;
        #1;
        chk("rd_hi1", rd_data, 32'hFFFF_FFFF);
        rd_hi = 1'b0;
        #1;
        chk("rd_hi0", rd_data, 32'hFFFF_FFD0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
